// File: rtl/mac_pkg.sv
// Shared MAC constants and the transmit framer state encoding.
// Used by the transmit framer and the CRC-32 byte engine.
package mac_pkg;

    localparam logic [7:0]  PREAMBLE_BYTE   = 8'h55;
    localparam logic [7:0]  SFD_BYTE        = 8'hD5;
    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
    localparam int          FCS_LEN         = 4;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        SFD,
        DATA,
        PAD,
        FCS,
        DRAIN,
        IPG
    } tx_state_e;

endpackage

// File: rtl/eth_crc32_d8.sv
// Combinational IEEE 802.3 CRC-32 step: folds one byte, LSB first, into the
// reflected CRC state. Shared by the transmit framer and the receive FCS checker.
module eth_crc32_d8
    import mac_pkg::*;
(
    input  logic [31:0] crc,
    input  logic [7:0]  data,
    output logic [31:0] crc_next
);

    always_comb begin
        crc_next = crc ^ {24'h000000, data};
        for (int i = 0; i < 8; i++) begin
            crc_next = crc_next[0] ? ((crc_next >> 1) ^ CRC32_POLY_REFL) : (crc_next >> 1);
        end
    end

endmodule

// File: rtl/mac_tx_framer.sv
// Egress MAC framer: preamble + SFD + payload (+ pad) + FCS, then inter-packet gap,
// onto a registered GMII-style byte interface. Padding is built only with MAC_TX_PAD_EN.
module mac_tx_framer
    import mac_pkg::*;
#(
    parameter int PREAMBLE_LEN = 7,
    parameter int MIN_FRAME    = 60,
    parameter int IPG_CYCLES   = 12,
    parameter int CNT_W        = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    input  logic        s_last,
    output logic        s_ready,
    output logic [7:0]  gmii_txd,
    output logic        gmii_tx_en,
    output logic        gmii_tx_er,
    output logic [31:0] frames_sent,
    output logic [15:0] underruns
);

`ifdef MAC_TX_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    localparam int CYC_MAX_A = (PREAMBLE_LEN > IPG_CYCLES) ? PREAMBLE_LEN : IPG_CYCLES;
    localparam int CYC_MAX   = (CYC_MAX_A > FCS_LEN) ? CYC_MAX_A : FCS_LEN;
    localparam int CYC_W     = $clog2(CYC_MAX + 1);

    localparam logic [CYC_W-1:0] PRE_LAST = CYC_W'(PREAMBLE_LEN - 1);
    localparam logic [CYC_W-1:0] FCS_LAST = CYC_W'(FCS_LEN - 1);
    localparam logic [CYC_W-1:0] IPG_LAST = CYC_W'(IPG_CYCLES - 1);
    localparam logic [CNT_W-1:0] MIN_CNT  = CNT_W'(MIN_FRAME);

    tx_state_e        state, state_d;
    logic [CYC_W-1:0] cyc, cyc_d;
    logic [CNT_W-1:0] cnt, cnt_d, cnt_inc;
    logic [31:0]      crc, crc_d, crc_fold, fcs;
    logic [7:0]       crc_byte;
    logic [7:0]       txd_d;
    logic             tx_en_d, tx_er_d;
    logic             frame_done, underrun;

    eth_crc32_d8 u_crc (
        .crc      (crc),
        .data     (crc_byte),
        .crc_next (crc_fold)
    );

    assign cnt_inc = (&cnt) ? cnt : cnt + 1'b1;
    assign fcs     = ~crc;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_d    = state;
        cyc_d      = cyc;
        cnt_d      = cnt;
        crc_d      = crc;
        txd_d      = 8'h00;
        tx_en_d    = 1'b0;
        tx_er_d    = 1'b0;
        s_ready    = 1'b0;
        crc_byte   = s_data;
        frame_done = 1'b0;
        underrun   = 1'b0;

        case (state)
            IDLE: begin
                if (s_valid) begin
                    state_d = PREAMBLE;
                    cyc_d   = '0;
                end
            end
            PREAMBLE: begin
                txd_d   = PREAMBLE_BYTE;
                tx_en_d = 1'b1;
                if (cyc == PRE_LAST) begin
                    state_d = SFD;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc + 1'b1;
                end
            end
            SFD: begin
                txd_d   = SFD_BYTE;
                tx_en_d = 1'b1;
                cnt_d   = '0;
                crc_d   = CRC32_INIT;
                state_d = DATA;
            end
            DATA: begin
                s_ready = 1'b1;
                tx_en_d = 1'b1;
                if (s_valid) begin
                    txd_d = s_data;
                    crc_d = crc_fold;
                    cnt_d = cnt_inc;
                    if (s_last) begin
                        state_d = (PAD_EN && (cnt_inc < MIN_CNT)) ? PAD : FCS;
                        cyc_d   = '0;
                    end
                end else begin
                    // Source starved mid-frame: mark the line and swallow the rest of the packet.
                    tx_er_d  = 1'b1;
                    underrun = 1'b1;
                    state_d  = DRAIN;
                end
            end
`ifdef MAC_TX_PAD_EN
            PAD: begin
                crc_byte = 8'h00;
                tx_en_d  = 1'b1;
                crc_d    = crc_fold;
                cnt_d    = cnt_inc;
                if (cnt_inc >= MIN_CNT) begin
                    state_d = FCS;
                    cyc_d   = '0;
                end
            end
`endif
            FCS: begin
                tx_en_d = 1'b1;
                txd_d   = fcs[{cyc[1:0], 3'b000} +: 8];
                if (cyc == FCS_LAST) begin
                    frame_done = 1'b1;
                    state_d    = IPG;
                    cyc_d      = '0;
                end else begin
                    cyc_d = cyc + 1'b1;
                end
            end
            DRAIN: begin
                s_ready = 1'b1;
                if (s_valid && s_last) begin
                    state_d = IPG;
                    cyc_d   = '0;
                end
            end
            IPG: begin
                if (cyc == IPG_LAST) begin
                    cyc_d   = '0;
                    state_d = s_valid ? PREAMBLE : IDLE;
                end else begin
                    cyc_d = cyc + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset here is asynchronous and active-high despite the rst_n name.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state       <= IDLE;
            cyc         <= '0;
            cnt         <= '0;
            crc         <= CRC32_INIT;
            gmii_txd    <= 8'h00;
            gmii_tx_en  <= 1'b0;
            gmii_tx_er  <= 1'b0;
            frames_sent <= '0;
            underruns   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state      <= state_d;
            cyc        <= cyc_d;
            cnt        <= cnt_d;
            crc        <= crc_d;
            gmii_txd   <= txd_d;
            gmii_tx_en <= tx_en_d;
            gmii_tx_er <= tx_er_d;
            if (frame_done) begin
                frames_sent <= frames_sent + 32'd1;
            end
            if (underrun && (underruns != 16'hFFFF)) begin
                underruns <= underruns + 16'd1;
            end
        end
    end

endmodule
